// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared instruction constants and field positions for the fetch stage
package fetch_pkg;
   localparam logic [15:0] NOP_INSTR = 16'h0000;
   localparam logic [3:0]  OPC_HALT  = 4'b1111;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int IMM_BIT = 11;
   localparam int RD_MSB  = 10;
   localparam int RD_LSB  = 8;
   localparam int RS1_MSB = 7;
   localparam int RS1_LSB = 5;
   localparam int RS2_MSB = 4;
   localparam int RS2_LSB = 2;

   function automatic logic is_halt(input logic [15:0] word);
      return word[OPC_MSB:OPC_LSB] == OPC_HALT;
   endfunction
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular word buffer, up to 2 writes and 0..2 reads per cycle, with flush
module fetch_queue #(
   parameter int  DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int OW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [1:0]    wr_cnt,
   input  logic [15:0]   wr_data0,
   input  logic [15:0]   wr_data1,
   input  logic [1:0]    rd_cnt,
   output logic [15:0]   head0,
   output logic [15:0]   head1,
   output logic [OW-1:0] occ
);
   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;

   assign head0 = mem[head];
   assign head1 = mem[head + AW'(1)];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         tail <= tail + AW'(wr_cnt);
         head <= head + AW'(rd_cnt);
         occ  <= occ - OW'(rd_cnt) + OW'(wr_cnt);
      end
   end

   // Storage needs no reset; pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         if (wr_cnt != 2'd0) mem[tail] <= wr_data0;
         if (wr_cnt == 2'd2) mem[tail + AW'(1)] <= wr_data1;
      end
   end
endmodule

// File: rtl/fetch_pair_unit.sv
// rtl/fetch_pair_unit.sv - PC, dual-word imem reads and instr pair presentation; FETCH_HALT_EN enables halt opcode
module fetch_pair_unit
   import fetch_pkg::*;
#(
   parameter int             QDEPTH   = 8,
   parameter int             PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_o,
   output logic [PC_W-1:0] imem_addr_o,
   input  logic [15:0]     imem_data0_i,
   input  logic [15:0]     imem_data1_i,
   output logic [15:0]     instr1_o,
   output logic [15:0]     instr2_o,
   output logic [1:0]      count_o,
   input  logic            isstall_i,
   input  logic            issingleinstr_i,
   input  logic            redirect_i,
   input  logic [PC_W-1:0] redirect_pc_i,
   output logic            halted_o
);
   localparam int OW = $clog2(QDEPTH) + 1;

   logic [PC_W-1:0] pc;
   logic            inflight;
   logic            drop;
   logic            halted;
   logic            resp;
   logic [1:0]      want;
   logic [1:0]      avail;
   logic [1:0]      consumed;
   logic [1:0]      wr_cnt;
   logic [15:0]     head0;
   logic [15:0]     head1;
   logic [OW-1:0]   occ;
   int              used;

   fetch_queue #(.DEPTH(QDEPTH)) u_queue (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect_i),
      .wr_cnt   (wr_cnt),
      .wr_data0 (imem_data0_i),
      .wr_data1 (imem_data1_i),
      .rd_cnt   (consumed),
      .head0    (head0),
      .head1    (head1),
      .occ      (occ)
   );

   assign avail    = (occ >= OW'(2)) ? 2'd2 : occ[1:0];
   assign want     = isstall_i ? 2'd0 : (issingleinstr_i ? 2'd1 : 2'd2);
   assign consumed = redirect_i ? 2'd0 : ((want < avail) ? want : avail);

   assign count_o  = avail;
   assign instr1_o = (avail >= 2'd1) ? head0 : NOP_INSTR;
   assign instr2_o = (avail == 2'd2) ? head1 : NOP_INSTR;

   // Credit check ignores same-cycle consumption so occupancy can never overshoot.
   assign used        = int'(occ) + (inflight ? 2 : 0);
   assign imem_req_o  = !rst && !halted && !redirect_i && (used + 2 <= QDEPTH);
   assign imem_addr_o = pc;
   assign resp        = inflight && !drop && !redirect_i && !halted;

`ifdef FETCH_HALT_EN
   logic halt_hit;

   assign halt_hit = resp && (is_halt(imem_data0_i) || is_halt(imem_data1_i));

   always_comb begin
      wr_cnt = 2'd0;
      if (resp) wr_cnt = is_halt(imem_data0_i) ? 2'd1 : 2'd2;
   end

   always_ff @(posedge clk) begin
      if (rst || redirect_i) halted <= 1'b0;
      else if (halt_hit)     halted <= 1'b1;
   end
`else
   assign wr_cnt = resp ? 2'd2 : 2'd0;
   assign halted = 1'b0;
`endif

   assign halted_o = halted;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         inflight <= 1'b0;
         drop     <= 1'b0;
      end else if (redirect_i) begin
         pc       <= redirect_pc_i;
         inflight <= 1'b0;
         drop     <= inflight;
      end else begin
         if (imem_req_o) pc <= pc + PC_W'(2);
         inflight <= imem_req_o;
         drop     <= 1'b0;
      end
   end
endmodule
